// File: rtl/elixirchip_es2_spu_op_mac.sv
// Pipelined signed multiply-accumulate operator with first-load, clear, wrap/saturate
// arithmetic, sticky overflow and registered output valid.
module elixirchip_es2_spu_op_mac #(
  parameter int                      LATENCY      = 3,
  parameter int                      S_DATA0_BITS = 8,
  parameter int                      S_DATA1_BITS = 8,
  parameter int                      ACC_BITS     = 32,
  parameter int                      M_DATA_BITS  = 16,
  parameter int                      DATA_SHIFT   = 0,
  parameter bit                      SATURATE     = 1'b0,
  parameter logic [M_DATA_BITS-1:0]  CLEAR_DATA   = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cke,
  input  logic [S_DATA0_BITS-1:0] s_data0,
  input  logic [S_DATA1_BITS-1:0] s_data1,
  input  logic                    s_first,
  input  logic                    s_clear,
  input  logic                    s_valid,
  output logic [M_DATA_BITS-1:0]  m_data,
  output logic                    m_valid,
  output logic                    m_overflow
);

  localparam int PROD_BITS = S_DATA0_BITS + S_DATA1_BITS;

  logic signed [PROD_BITS-1:0] w_prod;
  logic signed [ACC_BITS-1:0]  w_prod_ext;
  logic signed [ACC_BITS-1:0]  w_f_p;
  logic                        w_f_first;
  logic                        w_f_clear;
  logic                        w_f_valid;

  assign w_prod     = $signed(s_data0) * $signed(s_data1);
  assign w_prod_ext = ACC_BITS'(w_prod);

  generate
    if (LATENCY == 1) begin : g_direct
      assign w_f_p     = w_prod_ext;
      assign w_f_first = s_first;
      assign w_f_clear = s_clear;
      assign w_f_valid = s_valid;
    end else begin : g_pipe
      // Stages 1..LATENCY-1 only delay the product and its control bits.
      logic signed [ACC_BITS-1:0] r_p [LATENCY-1];
      logic [LATENCY-2:0]         r_first;
      logic [LATENCY-2:0]         r_clear;
      logic [LATENCY-2:0]         r_valid;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < LATENCY-1; i++) r_p[i] <= '0;
          r_first <= '0;
          r_clear <= '0;
          r_valid <= '0;
        end else if (cke) begin
          r_p[0]     <= w_prod_ext;
          r_first[0] <= s_first;
          r_clear[0] <= s_clear;
          r_valid[0] <= s_valid;
          for (int i = 1; i < LATENCY-1; i++) begin
            r_p[i]     <= r_p[i-1];
            r_first[i] <= r_first[i-1];
            r_clear[i] <= r_clear[i-1];
            r_valid[i] <= r_valid[i-1];
          end
        end
      end

      assign w_f_p     = r_p[LATENCY-2];
      assign w_f_first = r_first[LATENCY-2];
      assign w_f_clear = r_clear[LATENCY-2];
      assign w_f_valid = r_valid[LATENCY-2];
    end
  endgenerate

  logic signed [ACC_BITS-1:0]    r_acc;
  logic [M_DATA_BITS-1:0]        r_m_data;
  logic                          r_m_valid;
  logic                          r_m_overflow;

  logic signed [ACC_BITS:0]      w_sum;
  logic                          w_acc_ovf;
  logic signed [ACC_BITS-1:0]    w_acc_next;
  logic signed [ACC_BITS-1:0]    w_shift;
  logic [M_DATA_BITS-1:0]        w_narrow;
  logic                          w_nar_ovf;

  // One extra bit of headroom makes accumulator overflow a simple top-two-bit compare.
  always_comb begin
    w_sum = '0;
    if (w_f_first) w_sum = {w_f_p[ACC_BITS-1], w_f_p};
    else           w_sum = {r_acc[ACC_BITS-1], r_acc} + {w_f_p[ACC_BITS-1], w_f_p};
  end

  assign w_acc_ovf = w_sum[ACC_BITS] ^ w_sum[ACC_BITS-1];

  always_comb begin
    w_acc_next = w_sum[ACC_BITS-1:0];
    if (SATURATE && w_acc_ovf)
      w_acc_next = w_sum[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
  end

  assign w_shift = w_acc_next >>> DATA_SHIFT;

  generate
    if (M_DATA_BITS >= ACC_BITS) begin : g_nar_wide
      assign w_narrow  = M_DATA_BITS'(w_shift);
      assign w_nar_ovf = 1'b0;
    end else begin : g_nar_cut
      logic [ACC_BITS-M_DATA_BITS:0] w_hi;
      assign w_hi      = w_shift[ACC_BITS-1:M_DATA_BITS-1];
      assign w_nar_ovf = !((&w_hi) || (~|w_hi));
      always_comb begin
        w_narrow = w_shift[M_DATA_BITS-1:0];
        if (SATURATE && w_nar_ovf)
          w_narrow = w_shift[ACC_BITS-1] ? {1'b1, {(M_DATA_BITS-1){1'b0}}}
                                         : {1'b0, {(M_DATA_BITS-1){1'b1}}};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc        <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_overflow <= 1'b0;
    end else if (cke) begin
      if (w_f_clear) begin
        r_acc        <= '0;
        r_m_data     <= CLEAR_DATA;
        r_m_valid    <= 1'b0;
        r_m_overflow <= 1'b0;
      end else if (w_f_valid) begin
        r_acc        <= w_acc_next;
        r_m_data     <= w_narrow;
        r_m_valid    <= 1'b1;
        r_m_overflow <= (w_f_first ? 1'b0 : r_m_overflow) | w_acc_ovf | w_nar_ovf;
      end else begin
        r_m_valid    <= 1'b0;
      end
    end
  end

  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_overflow = r_m_overflow;

endmodule
